// File: rtl/seven_segment_scan_controller.sv
// Seven-segment scan controller.
//
// Time-multiplexes NUM_DIGITS 4-bit values onto a single shared seven-segment
// decoder. Each digit is preceded by a blanking gap of BLANK_CYCLES, during
// which no digit is driven, and is then driven for DWELL_CYCLES. New display
// data arrives through a valid/ready handshake into a shadow register. It is
// copied into the displayed (active) register only at a frame boundary, or
// while the display is off, so a frame never mixes old and new digits.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   en          scan enable; 0 turns the display off
//   load_valid  new display data offered
//   load_data   digit k = load_data[4k+3:4k]
//   load_ready  controller can accept load_data (registered)
//   nibble_out  decoder input, [3]=W (MSB) .. [0]=Z (registered)
//   digit_en    one-hot digit drive, active-high (registered)
//   blank       1 when no digit is driven (registered)
//   frame_done  one-cycle pulse after the last digit's dwell (registered)
module seven_segment_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blank,
  output logic                    frame_done
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned MaxCnt = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                  : BLANK_CYCLES;
  // cnt only ever holds 0 .. MaxCnt-1.
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  // Unused when there is no blanking gap; kept in range to avoid underflow.
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam bit              NoBlank   = (BLANK_CYCLES == 0);

  typedef enum logic [1:0] {
    StOff,
    StBlank,
    StDrive
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  // Output registers
  logic [3:0]              nibble_q, nibble_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    blank_q, blank_d;
  logic                    load_ready_q, load_ready_d;
  logic                    frame_done_q, frame_done_d;

  // Handshake and commit strobes
  logic transfer;
  logic commit;
  logic dwell_end;
  logic blank_end;

  assign transfer  = load_valid && !pending_q;
  assign dwell_end = (cnt_q == DwellLast);
  assign blank_end = (cnt_q == BlankLast);

  // ---------------------------------------------------------------------------
  // Scan sequencing: next state, digit index, counter, frame_done, commit
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + 1'b1;
    frame_done_d = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      StOff: begin
        idx_d  = '0;
        cnt_d  = '0;
        // While dark, pending data can be applied at any time.
        commit = pending_q;
        if (en) begin
          state_d = NoBlank ? StDrive : StBlank;
        end
      end

      StBlank: begin
        if (blank_end) begin
          state_d = StDrive;
          cnt_d   = '0;
        end
      end

      StDrive: begin
        if (dwell_end) begin
          cnt_d   = '0;
          state_d = NoBlank ? StDrive : StBlank;
          if (idx_q == IdxLast) begin
            idx_d        = '0;
            frame_done_d = 1'b1;
            commit       = pending_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StOff;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Disabling abandons the partial frame; only an OFF-state commit survives.
    if (!en) begin
      state_d      = StOff;
      idx_d        = '0;
      cnt_d        = '0;
      frame_done_d = 1'b0;
      commit       = commit && (state_q == StOff);
    end
  end

  // ---------------------------------------------------------------------------
  // Load handshake: shadow capture and commit into the displayed register.
  // A transfer needs pending=0 and a commit needs pending=1, so they are
  // mutually exclusive.
  // ---------------------------------------------------------------------------
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (transfer) begin
      shadow_d  = load_data;
      pending_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-state, derived from the next scan state so the registered
  // outputs always describe the state being entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble_d     = 4'h0;
    digit_en_d   = '0;
    blank_d      = (state_d != StDrive);
    load_ready_d = !pending_d;

    // The decoder input is presented during the blank gap too so its
    // outputs settle before the digit is switched on.
    if (state_d != StOff) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (idx_d == IdxW'(k)) begin
          nibble_d = active_d[4*k +: 4];
        end
      end
    end

    if (state_d == StDrive) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        digit_en_d[k] = (idx_d == IdxW'(k));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StOff;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nibble_q     <= 4'h0;
      digit_en_q   <= '0;
      blank_q      <= 1'b1;
      load_ready_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      nibble_q     <= nibble_d;
      digit_en_q   <= digit_en_d;
      blank_q      <= blank_d;
      load_ready_q <= load_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble_out = nibble_q;
  assign digit_en   = digit_en_q;
  assign blank      = blank_q;
  assign load_ready = load_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Testbench for seven_segment_scan_controller.
// Two instances share the stimulus: one with a 2-cycle blanking gap and one
// with none. Each is compared every cycle against a frame-position model.
module tb_seven_segment_scan_controller;

  localparam int Dwell = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic [15:0] load_data;

  logic        lr0, bl0, fd0, lr1, bl1, fd1;
  logic [3:0]  nib0, de0, nib1, de1;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Model: scan on/off, cycles since scan start, displayed/shadow data.
  bit          m_on[2];
  int          m_t[2];
  logic [15:0] m_active[2];
  logic [15:0] m_shadow[2];
  bit          m_pending[2];
  bit          m_fd[2];

  seven_segment_scan_controller #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(Dwell),
    .BLANK_CYCLES(2)
  ) dut_gap (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(lr0),
    .nibble_out(nib0),
    .digit_en  (de0),
    .blank     (bl0),
    .frame_done(fd0)
  );

  seven_segment_scan_controller #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(Dwell),
    .BLANK_CYCLES(0)
  ) dut_nogap (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(lr1),
    .nibble_out(nib1),
    .digit_en  (de1),
    .blank     (bl1),
    .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step(input int i, input int b);
    int period;
    bit was_on;
    bit commit;
    period = 4 * (b + Dwell);
    if (rst) begin
      m_on[i] = 0; m_t[i] = 0; m_active[i] = '0; m_shadow[i] = '0;
      m_pending[i] = 0; m_fd[i] = 0;
      return;
    end
    was_on = m_on[i];
    commit = 0;
    m_fd[i] = 0;
    if (!was_on) commit = m_pending[i];
    if (!en) begin
      m_on[i] = 0;
    end else if (!was_on) begin
      m_on[i] = 1;
      m_t[i]  = 0;
    end else begin
      m_t[i]++;
      if (m_t[i] % period == 0) begin
        m_fd[i] = 1;
        commit  = m_pending[i];
      end
    end
    if (commit) begin
      m_active[i]  = m_shadow[i];
      m_pending[i] = 0;
    end else if (load_valid && !m_pending[i]) begin
      m_shadow[i]  = load_data;
      m_pending[i] = 1;
    end
  endtask

  task automatic check_dut(input int i, input int b, input logic [3:0] de, input logic bl,
                           input logic [3:0] nib, input logic lr, input logic fd);
    int period, p, d, w;
    logic [3:0] e_de, e_nib;
    logic e_bl;
    period = 4 * (b + Dwell);
    if (m_on[i]) begin
      p     = m_t[i] % period;
      d     = p / (b + Dwell);
      w     = p % (b + Dwell);
      e_bl  = (w < b);
      e_de  = e_bl ? 4'b0000 : 4'(1 << d);
      e_nib = 4'((m_active[i] >> (4 * d)) & 16'hf);
    end else begin
      e_bl  = 1'b1;
      e_de  = 4'b0000;
      e_nib = 4'h0;
    end
    chk($sformatf("dut%0d.digit_en", i), 16'(de), 16'(e_de));
    chk($sformatf("dut%0d.blank", i), 16'(bl), 16'(e_bl));
    chk($sformatf("dut%0d.nibble_out", i), 16'(nib), 16'(e_nib));
    chk($sformatf("dut%0d.load_ready", i), 16'(lr), 16'(!m_pending[i]));
    chk($sformatf("dut%0d.frame_done", i), 16'(fd), 16'(m_fd[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0, 2);
    model_step(1, 0);
    #1;
    check_dut(0, 2, de0, bl0, nib0, lr0, fd0);
    check_dut(1, 0, de1, bl1, nib1, lr1, fd1);
  endtask

  initial begin
    int fd_cnt0, fd_cnt1;
    bit found;

    rst = 1'b1; en = 1'b1; load_valid = 1'b0; load_data = '0;

    // Reset held with en=1.
    for (int k = 0; k < 3; k++) tick();
    chk("reset_blank", 16'(bl0), 16'd1);
    chk("reset_ready", 16'(lr0), 16'd1);
    rst = 1'b0;
    tick();
    chk("first_after_reset_blank", 16'(bl0), 16'd1);
    chk("first_after_reset_nogap_drive", 16'(de1), 16'b0001);
    for (int k = 0; k < 5; k++) tick();

    // Load in OFF, then enable on the commit cycle.
    en = 1'b0;
    tick(); tick();
    load_valid = 1'b1; load_data = 16'h4321;
    tick();
    load_valid = 1'b0; en = 1'b1;
    fd_cnt0 = 0; fd_cnt1 = 0;
    for (int k = 0; k < 49; k++) begin
      tick();
      if (fd0) fd_cnt0++;
      if (fd1) fd_cnt1++;
    end
    chk("frame_done_count_gap", 16'(fd_cnt0), 16'd2);
    chk("frame_done_count_nogap", 16'(fd_cnt1), 16'd3);

    // Mid-frame load while digit 1 drives.
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (de0 == 4'b0010) found = 1;
    end
    chk("wait_digit1", 16'(found), 16'd1);
    load_valid = 1'b1; load_data = 16'hABCD;
    tick();
    load_valid = 1'b0;
    chk("ready_low_after_load", 16'(lr0), 16'd0);
    for (int k = 0; k < 40; k++) tick();

    // Drop en while digit 2 drives.
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (de0 == 4'b0100) found = 1;
    end
    chk("wait_digit2", 16'(found), 16'd1);
    en = 1'b0;
    tick();
    chk("drop_en_digit_off", 16'(de0), 16'd0);
    chk("drop_en_no_frame_done", 16'(fd0), 16'd0);
    en = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    // Reset during DRIVE with a load pending.
    load_valid = 1'b1; load_data = 16'h5555;
    tick();
    load_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (de0 != 4'b0000 && !lr0) found = 1;
    end
    chk("wait_drive_pending", 16'(found), 16'd1);
    rst = 1'b1;
    tick();
    chk("rst_ready", 16'(lr0), 16'd1);
    chk("rst_digit_off", 16'(de0), 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();

    // Randomised traffic.
    for (int k = 0; k < 1500; k++) begin
      rst        = ($urandom_range(0, 299) == 0);
      en         = ($urandom_range(0, 39) != 0);
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = 16'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
